decoder_scan_mxn: RTL and testbench

Registered, parametrised SIZE-to-2**SIZE one-hot decoder with selectable output polarity, plus an auto-scan mode. In scan mode the selected line advances through indices 0..last_in, holding each for DWELL clocks; this is the digit/row select for multiplexed displays and keypads. In direct mode it latches a_in on load_in and holds it. Sits between the control logic and the select pins or buffers.

---
 rtl/decoder_scan_mxn_pkg.sv | 32 +++
 rtl/decoder_scan_mxn_onehot_dec.sv | 27 ++
 rtl/decoder_scan_mxn.sv | 92 +++++++++
 tb/tb_decoder_scan_mxn.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_mxn_pkg.sv
// Shared types and helpers for the scanning one-hot select decoder family.
// Decoders of any width up to 2**MAX_SIZE lines slice the result of onehot_decode.
package decoder_scan_mxn_pkg;

  localparam int MAX_SIZE = 8;
  localparam int MAX_W    = 2 ** MAX_SIZE;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Dwell counter width: max(1, clog2(dwell)).
  function automatic int cnt_width(input int dwell);
    if (dwell <= 2) begin
      return 1;
    end else begin
      return $clog2(dwell);
    end
  endfunction

  function automatic logic [MAX_W-1:0] onehot_decode(input logic [MAX_SIZE-1:0] idx,
                                                     input logic active_low);
    logic [MAX_W-1:0] v;
    v      = {MAX_W{1'b0}};
    v[idx] = 1'b1;
    if (active_low) begin
      return ~v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/decoder_scan_mxn_onehot_dec.sv
// Combinational index-to-select-pattern decoder with polarity and blanking.
// Shared by the display digit scanner and keypad row drivers.
module decoder_scan_mxn_onehot_dec
  import decoder_scan_mxn_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [SIZE-1:0]    idx,
  input  logic               en,
  output logic [2**SIZE-1:0] pattern
);

  localparam int W = 2 ** SIZE;
  localparam logic [W-1:0] BLANK = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};

  // Select the decoded line, or blank when disabled.
  always_comb begin
    pattern = BLANK;
    if (en) begin
      pattern = W'(onehot_decode(MAX_SIZE'(idx), ACTIVE_LOW));
    end else begin
      pattern = BLANK;
    end
  end

endmodule

// File: rtl/decoder_scan_mxn.sv
// Registered one-hot select decoder with direct-load and auto-scan modes,
// used as digit/row select for multiplexed displays and keypads.
module decoder_scan_mxn
  import decoder_scan_mxn_pkg::*;
#(
  parameter int SIZE       = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DWELL      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode_in,
  input  logic               load_in,
  input  logic [SIZE-1:0]    a_in,
  input  logic [SIZE-1:0]    last_in,
  output logic [2**SIZE-1:0] b_out,
  output logic [SIZE-1:0]    idx_out,
  output logic               wrap_out
);

  localparam int W     = 2 ** SIZE;
  localparam int CNT_W = cnt_width(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [W-1:0]     BLANK    = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};

  logic [SIZE-1:0]  idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [SIZE-1:0]  idx_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             wrap_nxt_s;
  logic [W-1:0]     pattern_s;

  // Next index, dwell count and wrap pulse; en=0 freezes everything.
  always_comb begin
    idx_nxt_s  = idx_r;
    cnt_nxt_s  = cnt_r;
    wrap_nxt_s = 1'b0;
    if (!en) begin
      idx_nxt_s = idx_r;
      cnt_nxt_s = cnt_r;
    end else if (mode_in == MODE_DIRECT) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      if (load_in) begin
        idx_nxt_s = a_in;
      end else begin
        idx_nxt_s = idx_r;
      end
    end else if (load_in) begin
      idx_nxt_s = a_in;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r < CNT_LAST) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
      // >= also catches last_in lowered below the current index.
      if (idx_r >= last_in) begin
        idx_nxt_s  = {SIZE{1'b0}};
        wrap_nxt_s = 1'b1;
      end else begin
        idx_nxt_s  = idx_r + SIZE'(1);
      end
    end
  end

  decoder_scan_mxn_onehot_dec #(
    .SIZE       (SIZE),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .idx     (idx_nxt_s),
    .en      (en),
    .pattern (pattern_s)
  );

  // State and output registers, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= {SIZE{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      wrap_out <= 1'b0;
      b_out    <= BLANK;
    end else begin
      idx_r    <= idx_nxt_s;
      cnt_r    <= cnt_nxt_s;
      wrap_out <= wrap_nxt_s;
      b_out    <= pattern_s;
    end
  end

  assign idx_out = idx_r;

endmodule

// File: tb/tb_decoder_scan_mxn.sv
// Randomised and directed bench for decoder_scan_mxn against a behavioural model.
module tb_decoder_scan_mxn;

  logic       clk = 1'b0;
  logic       rst, en, mode_in, load_in;
  logic [1:0] a_in, last_in;

  logic [3:0] b_out, b_hi, b_d1;
  logic [1:0] idx_out, idx_hi, idx_d1;
  logic       wrap_out, wrap_hi, wrap_d1;

  int checks = 0;
  int errors = 0;

  // Model state: slot 0 = DWELL 3 (both polarities), slot 1 = DWELL 1.
  int m_idx[2];
  int m_cnt[2];
  bit m_wrap[2];
  bit m_on;
  int dwell_of[2] = '{3, 1};

  decoder_scan_mxn #(.SIZE(2), .ACTIVE_LOW(1'b1), .DWELL(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .load_in(load_in),
    .a_in(a_in), .last_in(last_in), .b_out(b_out), .idx_out(idx_out), .wrap_out(wrap_out));

  decoder_scan_mxn #(.SIZE(2), .ACTIVE_LOW(1'b0), .DWELL(3)) dut_hi (
    .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .load_in(load_in),
    .a_in(a_in), .last_in(last_in), .b_out(b_hi), .idx_out(idx_hi), .wrap_out(wrap_hi));

  decoder_scan_mxn #(.SIZE(2), .ACTIVE_LOW(1'b1), .DWELL(1)) dut_d1 (
    .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .load_in(load_in),
    .a_in(a_in), .last_in(last_in), .b_out(b_d1), .idx_out(idx_d1), .wrap_out(wrap_d1));

  always #5 clk = ~clk;

  function automatic int exp_b(int idx, bit active_low, bit on);
    int v;
    v = on ? (1 << idx) : 0;
    return active_low ? (~v & 15) : v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      if (rst) begin
        m_idx[k] = 0;
        m_cnt[k] = 0;
      end else if (!en) begin
        // frozen
      end else if (!mode_in) begin
        m_cnt[k] = 0;
        if (load_in) m_idx[k] = a_in;
      end else if (load_in) begin
        m_idx[k] = a_in;
        m_cnt[k] = 0;
      end else if (m_cnt[k] < dwell_of[k] - 1) begin
        m_cnt[k]++;
      end else begin
        m_cnt[k] = 0;
        if (m_idx[k] >= last_in) begin
          m_idx[k]  = 0;
          m_wrap[k] = 1'b1;
        end else begin
          m_idx[k]++;
        end
      end
    end
    m_on = !rst && en;
  endtask

  task automatic compare_all();
    check("b_out",     b_out,    exp_b(m_idx[0], 1'b1, m_on));
    check("idx_out",   idx_out,  m_idx[0]);
    check("wrap_out",  wrap_out, m_wrap[0]);
    check("b_hi",      b_hi,     exp_b(m_idx[0], 1'b0, m_on));
    check("idx_hi",    idx_hi,   m_idx[0]);
    check("wrap_hi",   wrap_hi,  m_wrap[0]);
    check("b_d1",      b_d1,     exp_b(m_idx[1], 1'b1, m_on));
    check("idx_d1",    idx_d1,   m_idx[1]);
    check("wrap_d1",   wrap_d1,  m_wrap[1]);
  endtask

  task automatic step(bit r, bit e, bit m, bit l, int a, int last);
    rst = r; en = e; mode_in = m; load_in = l;
    a_in = 2'(a); last_in = 2'(last);
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int wraps;
    int n;
    rst = 1'b1; en = 1'b0; mode_in = 1'b0; load_in = 1'b0; a_in = 2'd0; last_in = 2'd0;

    // 1. reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3), $urandom_range(3));
    check("lit_rst_b", b_out, 4'b1111);
    check("lit_rst_idx", idx_out, 0);
    check("lit_rst_wrap", wrap_out, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
    check("lit_first_b", b_out, 4'b1110);

    // 2. direct load and hold
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 3);
    check("lit_load_idx", idx_out, 2);
    check("lit_load_b", b_out, 4'b1011);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom_range(3), 3);
    check("lit_hold_b", b_out, 4'b1011);

    // 3. full scan from idx 0, last 3
    step(1'b0, 1'b1, 1'b0, 1'b1, 0, 3);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
      if (i == 2)  check("lit_scan_s2",  b_out, 4'b1110);
      if (i == 3)  check("lit_scan_s3",  b_out, 4'b1101);
      if (i == 8)  check("lit_scan_s8",  b_out, 4'b1011);
      if (i == 11) check("lit_scan_s11", b_out, 4'b0111);
      if (i == 11) check("lit_scan_nowrap", wrap_out, 0);
      if (i == 12) check("lit_scan_wrapb", b_out, 4'b1110);
      if (i == 12) check("lit_scan_wrap", wrap_out, 1);
    end

    // 4. shortened range, then last lowered under idx
    n = 0;
    while (m_idx[0] != 1 && n < 20) begin step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1); n++; end
    check("lit_reach_idx1", idx_out, 1);
    n = 0;
    do begin step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0); n++; end while (!m_wrap[0] && n < 10);
    check("lit_lowered_wrap", wrap_out, 1);
    check("lit_lowered_idx", idx_out, 0);
    wraps = 0;
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      if (wrap_out) wraps++;
    end
    check("lit_last0_wraps", wraps, 3);

    // 5. enable gap at idx 2, cnt 1
    step(1'b0, 1'b1, 1'b1, 1'b1, 2, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 3);
    check("lit_gap_b", b_out, 4'b1111);
    check("lit_gap_idx", idx_out, 2);
    check("lit_gap_wrap", wrap_out, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
    check("lit_resume_b", b_out, 4'b1011);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
    check("lit_resume_adv", b_out, 4'b0111);

    // 6. reset at a would-be wrap point, then polarity
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0, 0, 3);
    check("lit_midrst_idx", idx_out, 0);
    check("lit_midrst_b", b_out, 4'b1111);
    check("lit_midrst_wrap", wrap_out, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3, 3);
    check("lit_hi_b", b_hi, 4'b1000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 3, 3);
    check("lit_hi_blank", b_hi, 4'b0000);

    // 7. random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) < 2, $urandom_range(99) < 85, $urandom_range(99) < 70,
           $urandom_range(99) < 8, $urandom_range(3), $urandom_range(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
